// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB forwarding, and ALUSrc operand select.
module id_ex_stage #(
    parameter int XLEN = 64,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold_i,
    input  logic            bubble_i,
    input  logic            flush_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic [1:0]      id_alu_op_i,
    input  logic [2:0]      id_funct3_i,
    input  logic            id_funct7b5_i,
    input  logic            id_alu_src_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            id_mem_to_reg_i,
    input  logic            exm_reg_write_i,
    input  logic [RA_W-1:0] exm_rd_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic            mwb_reg_write_i,
    input  logic [RA_W-1:0] mwb_rd_i,
    input  logic [XLEN-1:0] mwb_result_i,
    output logic [XLEN-1:0] alu_x_o,
    output logic [XLEN-1:0] alu_y_o,
    output logic [3:0]      alu_ctrl_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic [RA_W-1:0] ex_rs1_o,
    output logic [RA_W-1:0] ex_rs2_o,
    output logic            ex_valid_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_mem_to_reg_o,
    output logic            illegal_o
);
    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            illegal;
        logic [3:0]      alu_ctrl;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } ex_t;
    ex_t             r, d;
    logic [3:0]      dec;
    logic [XLEN-1:0] fwd1, fwd2;
    always_comb begin
        dec = id_alu_op_i == 2'b00 ? 4'h2 :
              id_alu_op_i == 2'b01 ? 4'h6 :
              id_alu_op_i == 2'b11 ? 4'hF :
              id_funct3_i == 3'b000 ? (id_funct7b5_i ? 4'h6 : 4'h2) :
              id_funct3_i == 3'b111 ? 4'h0 :
              id_funct3_i == 3'b110 ? 4'h1 : 4'hF;
        d = '{
            valid:      id_valid_i,
            reg_write:  id_reg_write_i,
            mem_read:   id_mem_read_i,
            mem_write:  id_mem_write_i,
            mem_to_reg: id_mem_to_reg_i,
            alu_src:    id_alu_src_i,
            illegal:    id_valid_i && dec == 4'hF,
            alu_ctrl:   dec,
            rs1:        id_rs1_i,
            rs2:        id_rs2_i,
            rd:         id_rd_i,
            rs1_data:   id_rs1_data_i,
            rs2_data:   id_rs2_data_i,
            imm:        id_imm_i
        };
    end
    // flush beats hold, hold beats bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r          <= '0;
            r.alu_ctrl <= 4'hF;
        end else if (flush_i || (bubble_i && !hold_i)) begin
            r          <= '0;
            r.alu_ctrl <= 4'hF;
        end else if (!hold_i) begin
            r <= d;
        end
    end
    // x0 is hard-wired zero, so a write to it must never be forwarded
    always_comb begin
        fwd1 = (exm_reg_write_i && exm_rd_i != '0 && exm_rd_i == r.rs1) ? exm_result_i :
               (mwb_reg_write_i && mwb_rd_i != '0 && mwb_rd_i == r.rs1) ? mwb_result_i : r.rs1_data;
        fwd2 = (exm_reg_write_i && exm_rd_i != '0 && exm_rd_i == r.rs2) ? exm_result_i :
               (mwb_reg_write_i && mwb_rd_i != '0 && mwb_rd_i == r.rs2) ? mwb_result_i : r.rs2_data;
    end
    assign alu_x_o         = fwd1;
    assign alu_y_o         = r.alu_src ? r.imm : fwd2;
    assign store_data_o    = fwd2;
    assign alu_ctrl_o      = r.alu_ctrl;
    assign ex_rd_o         = r.rd;
    assign ex_rs1_o        = r.rs1;
    assign ex_rs2_o        = r.rs2;
    assign ex_valid_o      = r.valid;
    assign ex_reg_write_o  = r.reg_write;
    assign ex_mem_read_o   = r.mem_read;
    assign ex_mem_write_o  = r.mem_write;
    assign ex_mem_to_reg_o = r.mem_to_reg;
    assign illegal_o       = r.illegal;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table through a scoreboard queue, plus reset/hold/bubble/flush sequences.
module tb_id_ex_stage;
    logic        clk = 0;
    logic        rst_n, hold_i, bubble_i, flush_i, id_valid_i;
    logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [1:0]  id_alu_op_i;
    logic [2:0]  id_funct3_i;
    logic        id_funct7b5_i, id_alu_src_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
    logic        exm_reg_write_i, mwb_reg_write_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic [63:0] exm_result_i, mwb_result_i;
    logic [63:0] alu_x_o, alu_y_o, store_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  ex_rd_o, ex_rs1_o, ex_rs2_o;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, illegal_o;

    id_ex_stage #(.XLEN(64), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .bubble_i(bubble_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_alu_op_i(id_alu_op_i), .id_funct3_i(id_funct3_i), .id_funct7b5_i(id_funct7b5_i),
        .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
        .id_mem_write_i(id_mem_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
        .exm_reg_write_i(exm_reg_write_i), .exm_rd_i(exm_rd_i), .exm_result_i(exm_result_i),
        .mwb_reg_write_i(mwb_reg_write_i), .mwb_rd_i(mwb_rd_i), .mwb_result_i(mwb_result_i),
        .alu_x_o(alu_x_o), .alu_y_o(alu_y_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .ex_rd_o(ex_rd_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_valid_o(ex_valid_o),
        .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid; logic [1:0] op; logic [2:0] f3; logic b5; logic src; logic [3:0] ctl;
        logic [4:0]  rs1, rs2, rd; logic [63:0] d1, d2, imm;
        logic        ew; logic [4:0] erd; logic [63:0] eres;
        logic        mw; logic [4:0] mrd; logic [63:0] mres;
        logic [63:0] ex, ey, est; logic [3:0] ectrl; logic eill;
    } vec_t;

    typedef struct {
        logic [63:0] x, y, st; logic [3:0] ctrl; logic ill, valid; logic [3:0] ctl; logic [4:0] rd, rs1, rs2;
    } exp_t;

    vec_t v[15];
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, req);
        end
    endtask

    task automatic apply(input vec_t t);
        id_valid_i = t.valid; id_alu_op_i = t.op; id_funct3_i = t.f3; id_funct7b5_i = t.b5;
        id_alu_src_i = t.src;
        {id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i} = t.ctl;
        id_rs1_i = t.rs1; id_rs2_i = t.rs2; id_rd_i = t.rd;
        id_rs1_data_i = t.d1; id_rs2_data_i = t.d2; id_imm_i = t.imm;
        exm_reg_write_i = t.ew; exm_rd_i = t.erd; exm_result_i = t.eres;
        mwb_reg_write_i = t.mw; mwb_rd_i = t.mrd; mwb_result_i = t.mres;
    endtask

    task automatic chk_nop(input string n);
        cmp({n, "_valid"}, 64'(ex_valid_o), 0);
        cmp({n, "_rw"}, 64'(ex_reg_write_o), 0);
        cmp({n, "_ctrl"}, 64'(alu_ctrl_o), 64'hF);
        cmp({n, "_rd"}, 64'(ex_rd_o), 0);
        cmp({n, "_x"}, alu_x_o, 0);
    endtask

    initial begin
        //      valid op f3 b5 src ctl  rs1 rs2 rd d1 d2 imm ew erd eres mw mrd mres ex ey est ectrl eill
        v[0]  = '{1, 2, 0, 0, 0, 4'b1000, 1, 2, 3, 5, 7, 0, 0, 0, 0, 0, 0, 0, 5, 7, 7, 4'h2, 0};
        v[1]  = '{1, 2, 0, 1, 0, 4'b1000, 4, 5, 6, 10, 3, 0, 0, 0, 0, 0, 0, 0, 10, 3, 3, 4'h6, 0};
        v[2]  = '{1, 2, 7, 0, 0, 4'b1000, 1, 2, 7, 'hF0, 'h3C, 0, 0, 0, 0, 0, 0, 0, 'hF0, 'h3C, 'h3C, 4'h0, 0};
        v[3]  = '{1, 2, 6, 0, 0, 4'b1000, 1, 2, 7, 'hF0, 'h3C, 0, 0, 0, 0, 0, 0, 0, 'hF0, 'h3C, 'h3C, 4'h1, 0};
        v[4]  = '{1, 0, 5, 1, 1, 4'b1101, 1, 2, 8, 'h100, 'h7, 'h20, 0, 0, 0, 0, 0, 0, 'h100, 'h20, 'h7, 4'h2, 0};
        v[5]  = '{1, 1, 0, 0, 0, 4'b0000, 1, 2, 0, 'h9, 'h4, 0, 0, 0, 0, 0, 0, 0, 'h9, 'h4, 'h4, 4'h6, 0};
        v[6]  = '{1, 2, 4, 0, 0, 4'b1000, 1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'hF, 1};
        v[7]  = '{1, 3, 0, 0, 0, 4'b0000, 1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'hF, 1};
        v[8]  = '{0, 2, 4, 0, 0, 4'b0000, 1, 2, 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4'hF, 0};
        v[9]  = '{1, 2, 0, 0, 0, 4'b1000, 3, 3, 9, 'h11, 'h22, 0, 1, 3, 'hAAAA, 1, 3, 'h5555, 'hAAAA, 'hAAAA, 'hAAAA, 4'h2, 0};
        v[10] = '{1, 2, 0, 0, 0, 4'b1000, 3, 3, 9, 'h11, 'h22, 0, 0, 3, 'hAAAA, 1, 3, 'h5555, 'h5555, 'h5555, 'h5555, 4'h2, 0};
        v[11] = '{1, 2, 0, 0, 0, 4'b1000, 3, 3, 9, 'h11, 'h22, 0, 1, 0, 'hAAAA, 1, 0, 'h5555, 'h11, 'h22, 'h22, 4'h2, 0};
        v[12] = '{1, 2, 0, 0, 0, 4'b1000, 0, 0, 9, 'h33, 'h44, 0, 1, 0, 'hAAAA, 0, 0, 0, 'h33, 'h44, 'h44, 4'h2, 0};
        v[13] = '{1, 0, 3, 0, 1, 4'b0010, 1, 4, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1, 4, 9, 1, 64'hFFFF_FFFF_FFFF_FFFC, 9, 4'h2, 0};
        v[14] = '{1, 2, 0, 0, 0, 4'b1000, 5, 6, 7, 1, 2, 0, 1, 6, 'h66, 1, 5, 'h55, 'h55, 'h66, 'h66, 4'h2, 0};

        rst_n = 0; hold_i = 0; bubble_i = 0; flush_i = 0;
        apply(v[0]);
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_ctrl", 64'(alu_ctrl_o), 64'hF);
        cmp("rst_x", alu_x_o, 0);
        cmp("rst_y", alu_y_o, 0);
        cmp("rst_valid", 64'(ex_valid_o), 0);
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            apply(v[i]);
            q.push_back('{v[i].ex, v[i].ey, v[i].est, v[i].ectrl, v[i].eill, v[i].valid, v[i].ctl, v[i].rd, v[i].rs1, v[i].rs2});
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty vec %0d: got 0 entries expected 1", i);
            end else begin
                checks--;
                e = q.pop_front();
                cmp($sformatf("v%0d_x", i), alu_x_o, e.x);
                cmp($sformatf("v%0d_y", i), alu_y_o, e.y);
                cmp($sformatf("v%0d_st", i), store_data_o, e.st);
                cmp($sformatf("v%0d_ctrl", i), 64'(alu_ctrl_o), 64'(e.ctrl));
                cmp($sformatf("v%0d_ill", i), 64'(illegal_o), 64'(e.ill));
                cmp($sformatf("v%0d_valid", i), 64'(ex_valid_o), 64'(e.valid));
                cmp($sformatf("v%0d_ctl", i), 64'({ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o}), 64'(e.ctl));
                cmp($sformatf("v%0d_rd", i), 64'(ex_rd_o), 64'(e.rd));
                cmp($sformatf("v%0d_rs", i), 64'({ex_rs1_o, ex_rs2_o}), 64'({e.rs1, e.rs2}));
            end
        end

        @(negedge clk);
        hold_i = 1; id_alu_op_i = 1; id_valid_i = 0; id_rs1_data_i = 99; id_rs1_i = 9;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            cmp($sformatf("hold%0d_ctrl", k), 64'(alu_ctrl_o), 64'h2);
            cmp($sformatf("hold%0d_x", k), alu_x_o, 64'h55);
            cmp($sformatf("hold%0d_valid", k), 64'(ex_valid_o), 1);
        end

        @(negedge clk);
        hold_i = 0; bubble_i = 1;
        @(posedge clk);
        #1;
        chk_nop("bubble");
        cmp("bubble_ill", 64'(illegal_o), 0);

        @(negedge clk);
        bubble_i = 0;
        apply(v[0]);
        @(posedge clk);
        #1;
        cmp("pre_flush_ctrl", 64'(alu_ctrl_o), 64'h2);
        cmp("pre_flush_x", alu_x_o, 5);
        @(negedge clk);
        flush_i = 1; hold_i = 1;
        @(posedge clk);
        #1;
        chk_nop("flush_hold");
        @(negedge clk);
        flush_i = 0; hold_i = 0;
        @(posedge clk);
        #1;
        cmp("post_flush_x", alu_x_o, 5);
        hold_i = 1;
        #2 rst_n = 0;
        #1;
        chk_nop("midrst");
        cmp("midrst_y", alu_y_o, 0);
        cmp("midrst_st", store_data_o, 0);
        @(negedge clk);
        rst_n = 1; hold_i = 0;
        @(posedge clk);
        #1;
        cmp("rel_x", alu_x_o, 5);
        cmp("rel_y", alu_y_o, 7);
        cmp("rel_ctrl", 64'(alu_ctrl_o), 64'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
